// File: rtl/grf_dump_reader_pkg.sv
// Shared definitions for the GRF dump reader: walk FSM encoding and the
// GRF geometry constants shared with the register file.
package grf_dump_reader_pkg;

   localparam int GRF_ADDR_W = 5;
   localparam int GRF_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_DONE  = 2'd3
   } dump_state_e;

   // Running dump signature: plain XOR fold, no carry.
   function automatic logic [GRF_DATA_W-1:0] sig_fold(
      input logic [GRF_DATA_W-1:0] acc,
      input logic [GRF_DATA_W-1:0] word
   );
      return acc ^ word;
   endfunction

endpackage

// File: rtl/grf_dump_reader.sv
// Walks every GRF register through one combinational read port and streams
// {index, value} words over valid/ready, holding GRF writes while busy.
module grf_dump_reader
   import grf_dump_reader_pkg::*;
#(
   parameter int NUM_REGS  = 32,
   parameter int ADDR_W    = GRF_ADDR_W,
   parameter int DATA_W    = GRF_DATA_W,
   parameter int SKIP_ZERO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_hold,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [ADDR_W-1:0] o_out_idx,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_checksum
);

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? ADDR_W'(1) : ADDR_W'(0);

   dump_state_e       r_state;
   dump_state_e       w_state_nxt;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_out_idx;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;
   logic [DATA_W-1:0] r_checksum;
   logic              r_out_valid;
   logic              r_busy;
   logic              r_done;
   logic              w_accept;

   assign w_accept = (r_state == ST_SEND) && i_out_ready;

   // Next-state decode for the walk.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_start) w_state_nxt = ST_FETCH;
            else         w_state_nxt = ST_IDLE;
         end
         ST_FETCH: w_state_nxt = ST_SEND;
         ST_SEND: begin
            if (w_accept) begin
               if (r_out_last) w_state_nxt = ST_DONE;
               else            w_state_nxt = ST_FETCH;
            end else begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Walk index, captured output word and running checksum.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx      <= {ADDR_W{1'b0}};
         r_out_idx  <= {ADDR_W{1'b0}};
         r_out_data <= {DATA_W{1'b0}};
         r_out_last <= 1'b0;
         r_checksum <= {DATA_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_idx      <= FIRST_IDX;
                  r_checksum <= {DATA_W{1'b0}};
               end
            end
            ST_FETCH: begin
               r_out_data <= i_rd_data;
               r_out_idx  <= r_idx;
               r_out_last <= (r_idx == LAST_IDX);
            end
            ST_SEND: begin
               // idx stops at the last register so it never wraps.
               if (w_accept) begin
                  r_checksum <= sig_fold(r_checksum, r_out_data);
                  if (!r_out_last) r_idx <= r_idx + ADDR_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status flags registered from the next state so they align with r_state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_out_valid <= (w_state_nxt == ST_SEND);
         r_busy      <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_SEND);
         r_done      <= (w_state_nxt == ST_DONE);
      end
   end

   assign o_rd_addr   = r_idx;
   assign o_hold      = r_busy;
   assign o_busy      = r_busy;
   assign o_out_valid = r_out_valid;
   assign o_out_idx   = r_out_idx;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;
   assign o_done      = r_done;
   assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_grf_dump_reader.sv
// Scoreboard bench for grf_dump_reader: one instance per SKIP_ZERO setting,
// a behavioural GRF with a hold-gated pipeline write port.
module tb_grf_dump_reader;

   localparam int NR = 32;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0] rf [NR];

   logic          sel = 1'b0;
   logic          start_s = 1'b0;
   logic          ready_s = 1'b1;
   logic          pipe_we = 1'b0;
   logic [AW-1:0] pipe_addr = 5'd0;
   logic [DW-1:0] pipe_wdata = 32'd0;

   logic a_start, a_hold, a_valid, a_ready, a_last, a_busy, a_done;
   logic b_start, b_hold, b_valid, b_ready, b_last, b_busy, b_done;
   logic [AW-1:0] a_rd_addr, a_idx, b_rd_addr, b_idx;
   logic [DW-1:0] a_rd_data, a_data, a_sum, b_rd_data, b_data, b_sum;

   assign a_start   = start_s & ~sel;
   assign b_start   = start_s & sel;
   assign a_ready   = ready_s & ~sel;
   assign b_ready   = ready_s & sel;
   assign a_rd_data = rf[a_rd_addr];
   assign b_rd_data = rf[b_rd_addr];

   grf_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(0)) u_dut_a (
      .clk(clk), .reset(reset), .i_start(a_start), .o_rd_addr(a_rd_addr),
      .i_rd_data(a_rd_data), .o_hold(a_hold), .o_out_valid(a_valid),
      .i_out_ready(a_ready), .o_out_idx(a_idx), .o_out_data(a_data),
      .o_out_last(a_last), .o_busy(a_busy), .o_done(a_done), .o_checksum(a_sum)
   );

   grf_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1)) u_dut_b (
      .clk(clk), .reset(reset), .i_start(b_start), .o_rd_addr(b_rd_addr),
      .i_rd_data(b_rd_data), .o_hold(b_hold), .o_out_valid(b_valid),
      .i_out_ready(b_ready), .o_out_idx(b_idx), .o_out_data(b_data),
      .o_out_last(b_last), .o_busy(b_busy), .o_done(b_done), .o_checksum(b_sum)
   );

   logic          m_valid, m_ready, m_last, m_busy, m_hold, m_done;
   logic [AW-1:0] m_idx, m_rd_addr;
   logic [DW-1:0] m_data, m_sum;
   assign m_valid   = sel ? b_valid   : a_valid;
   assign m_ready   = sel ? b_ready   : a_ready;
   assign m_last    = sel ? b_last    : a_last;
   assign m_busy    = sel ? b_busy    : a_busy;
   assign m_hold    = sel ? b_hold    : a_hold;
   assign m_done    = sel ? b_done    : a_done;
   assign m_idx     = sel ? b_idx     : a_idx;
   assign m_rd_addr = sel ? b_rd_addr : a_rd_addr;
   assign m_data    = sel ? b_data    : a_data;
   assign m_sum     = sel ? b_sum     : a_sum;

   word_t         exp_q [$];
   logic [DW-1:0] exp_sum = 32'd0;
   int            n_vec = 0;
   int            n_err = 0;
   int            n_done = 0;
   int            blocked = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every accepted word, checks stall stability.
   initial begin
      logic  stall_prev;
      word_t held;
      word_t got;
      word_t want;
      stall_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            check("hold_eq_busy", 64'(m_hold), 64'(m_busy));
            got = {m_idx, m_data, m_last};
            if (m_valid && stall_prev) check("stall_stable", 64'(got), 64'(held));
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_word", 64'(exp_q.size()), 64'd1);
               end else begin
                  want = exp_q.pop_front();
                  check("word_idx", 64'(m_idx), 64'(want.idx));
                  check("word_data", 64'(m_data), 64'(want.data));
                  check("word_last", 64'(m_last), 64'(want.last));
               end
            end
            stall_prev = m_valid && !m_ready;
            held = got;
            if (m_done) begin
               n_done++;
               check("checksum", 64'(m_sum), 64'(exp_sum));
               check("words_left_at_done", 64'(exp_q.size()), 64'd0);
            end
         end
      end
   end

   task automatic preload();
      for (int i = 0; i < NR; i++) rf[i] = i * 32'h1111_1111;
   endtask

   // ready_mode: 0 always ready, 1 toggles each cycle, 2 low every third cycle.
   task automatic run_dump(input logic skip, input int ready_mode, input int pulse_cyc,
                           input logic wr, input int exp_cyc, input int abort_cyc);
      int    cyc;
      int    d0;
      word_t w;
      sel = skip;
      exp_q.delete();
      exp_sum = 32'd0;
      for (int i = (skip ? 1 : 0); i < NR; i++) begin
         w.idx  = AW'(i);
         w.data = rf[i];
         w.last = (i == NR - 1);
         exp_q.push_back(w);
         exp_sum = exp_sum ^ rf[i];
      end
      d0 = n_done;
      @(posedge clk);
      #1;
      start_s = 1'b1;
      ready_s = 1'b1;
      cyc = 1;
      while (cyc < 400) begin
         @(negedge clk);
         if (pipe_we) begin
            if (a_hold || b_hold) blocked++;
            else                  rf[pipe_addr] = pipe_wdata;
         end
         if (m_done) break;
         @(posedge clk);
         cyc++;
         #1;
         start_s = (cyc == pulse_cyc);
         case (ready_mode)
            1:       ready_s = cyc[0];
            2:       ready_s = (cyc % 3) != 0;
            default: ready_s = 1'b1;
         endcase
         pipe_we    = wr && (cyc >= 2) && (cyc <= 65);
         pipe_addr  = cyc[AW-1:0];
         pipe_wdata = 32'hDEAD_0000 | 32'(cyc);
         if (cyc == abort_cyc) begin
            reset = 1'b1;
            break;
         end
      end
      start_s = 1'b0;
      pipe_we = 1'b0;
      if (abort_cyc > 0) begin
         @(posedge clk);
         #1;
         reset = 1'b0;
         @(negedge clk);
         check("abort_outputs", 64'({m_valid, m_idx, m_data, m_last, m_busy, m_hold, m_done}), 64'd0);
         check("abort_rd_addr", 64'(m_rd_addr), 64'd0);
         check("abort_checksum", 64'(m_sum), 64'd0);
         exp_q.delete();
         repeat (4) @(negedge clk);
         check("abort_no_done", 64'(n_done - d0), 64'd0);
      end else begin
         check("done_timeout", 64'(cyc < 400), 64'd1);
         if (exp_cyc > 0) check("done_cycle", 64'(cyc), 64'(exp_cyc));
         repeat (3) @(negedge clk);
         check("done_pulses", 64'(n_done - d0), 64'd1);
         check("busy_after_done", 64'(m_busy), 64'd0);
      end
      ready_s = 1'b1;
   endtask

   initial begin
      preload();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_a", 64'({a_valid, a_idx, a_data, a_last, a_busy, a_hold, a_done, a_rd_addr}), 64'd0);
      check("reset_a_sum", 64'(a_sum), 64'd0);
      check("reset_b", 64'({b_valid, b_idx, b_data, b_last, b_busy, b_hold, b_done, b_rd_addr}), 64'd0);
      check("reset_b_sum", 64'(b_sum), 64'd0);

      run_dump(1'b0, 0, 0, 1'b0, 66, 0);   // full walk, ready always high
      run_dump(1'b1, 0, 0, 1'b0, 64, 0);   // SKIP_ZERO instance
      run_dump(1'b0, 1, 0, 1'b0, 0, 0);    // ready toggling every cycle
      run_dump(1'b0, 2, 0, 1'b0, 0, 0);    // ready low every third cycle
      run_dump(1'b0, 0, 11, 1'b0, 66, 0);  // second start during 5th word
      run_dump(1'b0, 0, 0, 1'b0, 0, 23);   // reset during SEND of idx 10
      run_dump(1'b0, 0, 0, 1'b0, 66, 0);   // fresh walk after abort

      blocked = 0;
      run_dump(1'b0, 0, 0, 1'b1, 66, 0);   // pipeline writes while held
      check("blocked_writes", 64'(blocked), 64'd64);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
